// File: rtl/md5_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : md5_pkg
//  Brief   : Shared constants and FSM encoding for the MD5 hex text output.
//            MD5_HEX_CRLF_EN (optional) appends CR/LF after the 32 hex chars.
//  Revision: 1.0  initial release
// ============================================================================
package md5_pkg;

  // MD5 initialisation vector (words A..D)
  localparam logic [31:0] MD5_IV_A = 32'h67452301;
  localparam logic [31:0] MD5_IV_B = 32'hEFCDAB89;
  localparam logic [31:0] MD5_IV_C = 32'h98BADCFE;
  localparam logic [31:0] MD5_IV_D = 32'h10325476;

  localparam int          HEX_CHARS = 32;
  localparam logic [7:0]  ASCII_CR  = 8'h0D;
  localparam logic [7:0]  ASCII_LF  = 8'h0A;

  // FSM encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_SEND = 2'd1;
  localparam state_t ST_GAP  = 2'd2;

endpackage : md5_pkg
`default_nettype wire

// File: rtl/md5_hex_out_nibble.sv
`default_nettype none
// ============================================================================
//  Module  : nibble_to_ascii
//  Brief   : Combinational 4-bit value to lowercase ASCII hex digit.
//  Revision: 1.0  initial release
// ============================================================================
module nibble_to_ascii (
  input  logic [3:0] nibble_i,
  output logic [7:0] ascii_o
);

  // 0-9 map onto '0'..'9'; 10-15 map onto 'a'..'f' (8'h57 + 10 = 8'h61)
  always_comb begin
    if (nibble_i < 4'd10) ascii_o = 8'h30 + {4'h0, nibble_i};
    else                  ascii_o = 8'h57 + {4'h0, nibble_i};
  end

endmodule : nibble_to_ascii
`default_nettype wire

// File: rtl/md5_hex_out.sv
`default_nettype none
// ============================================================================
//  Module  : md5_hex_out
//  Brief   : Latches the final MD5 digest and streams it as lowercase ASCII
//            hex over a valid/ready interface. Define MD5_HEX_CRLF_EN to
//            append CR and LF after the 32 hex characters.
//  Revision: 1.0  initial release
// ============================================================================
module md5_hex_out
  import md5_pkg::*;
#(
  parameter int LE_ORDER   = 1,
  parameter int GAP_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        digest_valid,
  input  logic [31:0] digest_a,
  input  logic [31:0] digest_b,
  input  logic [31:0] digest_c,
  input  logic [31:0] digest_d,
  output logic        char_valid,
  output logic [7:0]  char_data,
  input  logic        char_ready,
  output logic        char_last,
  output logic        busy,
  output logic        done,
  output logic        overrun
);

`ifdef MD5_HEX_CRLF_EN
  localparam logic [5:0] c_LAST_IDX = 6'(HEX_CHARS + 1);
`else
  localparam logic [5:0] c_LAST_IDX = 6'(HEX_CHARS - 1);
`endif
  localparam logic [7:0] c_GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  state_t         state_q, state_d;
  logic [5:0]     idx_q, idx_d;
  logic [7:0]     gap_q, gap_d;
  logic [127:0]   shadow_q, shadow_d;
  logic           done_q, done_d;
  logic           overrun_q, overrun_d;
  logic           char_valid_q;
  logic [7:0]     char_data_q;
  logic           char_last_q;

  logic           w_hs;
  logic [31:0]    w_word;
  logic [7:0]     w_byte;
  logic [3:0]     w_nibble;
  logic [7:0]     w_hex;
  logic [7:0]     w_char;

  assign w_hs = char_valid_q & char_ready;

  // Next-state: capture, per-char advance, inter-char gap and overrun detection
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    gap_d     = gap_q;
    shadow_d  = shadow_q;
    done_d    = 1'b0;
    overrun_d = overrun_q;
    case (state_q)
      ST_IDLE: begin
        if (digest_valid) begin
          shadow_d = {digest_a, digest_b, digest_c, digest_d};
          state_d  = ST_SEND;
          idx_d    = 6'd0;
        end
      end
      ST_SEND: begin
        if (w_hs) begin
          if (idx_q == c_LAST_IDX) begin
            state_d = ST_IDLE;
            idx_d   = 6'd0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 6'd1;
            if (GAP_CYCLES > 0) begin
              state_d = ST_GAP;
              gap_d   = 8'd0;
            end
          end
        end
      end
      ST_GAP: begin
        if (gap_q == c_GAP_LAST) begin
          state_d = ST_SEND;
          gap_d   = 8'd0;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = 6'd0;
        gap_d   = 8'd0;
      end
    endcase
    // A digest arriving while busy (including the final-handshake cycle) is lost
    if (digest_valid && (state_q != ST_IDLE)) overrun_d = 1'b1;
  end

  // Select the word for the next character from the next-state shadow/index
  always_comb begin
    case (idx_d[4:3])
      2'd0:    w_word = shadow_d[127:96];
      2'd1:    w_word = shadow_d[95:64];
      2'd2:    w_word = shadow_d[63:32];
      default: w_word = shadow_d[31:0];
    endcase
  end

  generate
    if (LE_ORDER != 0) begin : g_le
      // Standard MD5 text: least-significant byte of each word first
      always_comb begin
        case (idx_d[2:1])
          2'd0:    w_byte = w_word[7:0];
          2'd1:    w_byte = w_word[15:8];
          2'd2:    w_byte = w_word[23:16];
          default: w_byte = w_word[31:24];
        endcase
      end
    end else begin : g_be
      // Raw word order: most-significant byte first
      always_comb begin
        case (idx_d[2:1])
          2'd0:    w_byte = w_word[31:24];
          2'd1:    w_byte = w_word[23:16];
          2'd2:    w_byte = w_word[15:8];
          default: w_byte = w_word[7:0];
        endcase
      end
    end
  endgenerate

  assign w_nibble = idx_d[0] ? w_byte[3:0] : w_byte[7:4];

  nibble_to_ascii u_nibble_to_ascii (
    .nibble_i (w_nibble),
    .ascii_o  (w_hex)
  );

`ifdef MD5_HEX_CRLF_EN
  // Trailing line terminator after the hex digits
  always_comb begin
    if (idx_d == 6'(HEX_CHARS))          w_char = ASCII_CR;
    else if (idx_d == 6'(HEX_CHARS + 1)) w_char = ASCII_LF;
    else                                 w_char = w_hex;
  end
`else
  assign w_char = w_hex;
`endif

  // State and output registers; outputs load from next state so the first
  // character appears the cycle after capture and holds while stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= 6'd0;
      gap_q        <= 8'd0;
      shadow_q     <= '0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
      char_valid_q <= 1'b0;
      char_data_q  <= 8'h00;
      char_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      gap_q        <= gap_d;
      shadow_q     <= shadow_d;
      done_q       <= done_d;
      overrun_q    <= overrun_d;
      char_valid_q <= (state_d == ST_SEND);
      char_data_q  <= (state_d == ST_SEND) ? w_char : 8'h00;
      char_last_q  <= (state_d == ST_SEND) && (idx_d == c_LAST_IDX);
    end
  end

  assign char_valid = char_valid_q;
  assign char_data  = char_data_q;
  assign char_last  = char_last_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign overrun    = overrun_q;

endmodule : md5_hex_out
`default_nettype wire

// File: tb/tb_md5_hex_out.sv
`default_nettype none
// ============================================================================
//  Module  : tb_md5_hex_out
//  Brief   : Directed self-checking bench for md5_hex_out. Instance A uses
//            LE_ORDER=1/GAP_CYCLES=0, instance B uses LE_ORDER=0/GAP_CYCLES=3.
//            Honours MD5_HEX_CRLF_EN when defined.
//  Revision: 1.0  initial release
// ============================================================================
module tb_md5_hex_out;

`ifdef MD5_HEX_CRLF_EN
  localparam int NCH = 34;
`else
  localparam int NCH = 32;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        dv;
  logic        sel;
  logic [31:0] dg_a, dg_b, dg_c, dg_d;
  logic        rdy;

  logic        a_dv, a_valid, a_last, a_busy, a_done, a_ovr;
  logic [7:0]  a_data;
  logic        b_dv, b_valid, b_last, b_busy, b_done, b_ovr;
  logic [7:0]  b_data;

  logic        m_valid, m_last, m_busy, m_done, m_ovr;
  logic [7:0]  m_data;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Route stimulus/observation to the selected instance
  always_comb begin
    a_dv    = dv & ~sel;
    b_dv    = dv & sel;
    m_valid = sel ? b_valid : a_valid;
    m_data  = sel ? b_data  : a_data;
    m_last  = sel ? b_last  : a_last;
    m_busy  = sel ? b_busy  : a_busy;
    m_done  = sel ? b_done  : a_done;
    m_ovr   = sel ? b_ovr   : a_ovr;
  end

  md5_hex_out #(.LE_ORDER(1), .GAP_CYCLES(0)) dut_a (
    .clk(clk), .reset(reset), .digest_valid(a_dv),
    .digest_a(dg_a), .digest_b(dg_b), .digest_c(dg_c), .digest_d(dg_d),
    .char_valid(a_valid), .char_data(a_data), .char_ready(rdy),
    .char_last(a_last), .busy(a_busy), .done(a_done), .overrun(a_ovr)
  );

  md5_hex_out #(.LE_ORDER(0), .GAP_CYCLES(3)) dut_b (
    .clk(clk), .reset(reset), .digest_valid(b_dv),
    .digest_a(dg_a), .digest_b(dg_b), .digest_c(dg_c), .digest_d(dg_d),
    .char_valid(b_valid), .char_data(b_data), .char_ready(rdy),
    .char_last(b_last), .busy(b_busy), .done(b_done), .overrun(b_ovr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_char(input string s, input int k);
    if (k < 32)       return s[k];
    else if (k == 32) return 8'h0D;
    else              return 8'h0A;
  endfunction

  // Present a digest for one edge, then check first-char latency
  task automatic start(input logic [127:0] dg);
    {dg_a, dg_b, dg_c, dg_d} = dg;
    dv = 1'b1;
    @(posedge clk); #1;
    dv = 1'b0;
    chk("latency_valid", m_valid, 1'b1);
    chk("latency_busy", m_busy, 1'b1);
  endtask

  // Consume a whole stream. mode 0: ready=1, 1: toggling, 2: random.
  // inj=1 pulses digest_valid at char 10 and on the final handshake.
  task automatic stream(input string exp, input int mode, input int gap, input bit inj);
    int k = 0;
    int cyc = 0;
    int last_hs = -1;
    bit stalled = 1'b0;
    bit inj10 = 1'b0;
    logic [7:0] held = 8'h00;
    while (k < NCH && cyc < 600) begin
      dv = 1'b0;
      dg_a = $urandom; dg_b = $urandom; dg_c = $urandom; dg_d = $urandom;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      if (m_valid) begin
        if (stalled) chk("stall_stable", m_data, held);
        chk($sformatf("char%0d", k), m_data, exp_char(exp, k));
        chk($sformatf("last%0d", k), m_last, (k == NCH - 1));
        if (inj && k == 10 && !inj10) begin
          dv = 1'b1;
          inj10 = 1'b1;
        end
        if (rdy) begin
          if (mode == 0 && last_hs >= 0) chk("hs_spacing", cyc - last_hs, gap + 1);
          if (inj && k == NCH - 1) dv = 1'b1;
          last_hs = cyc;
          k++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held = m_data;
        end
      end
      cyc++;
      @(posedge clk); #1;
    end
    dv  = 1'b0;
    rdy = 1'b0;
    chk("stream_complete", k, NCH);
    chk("done_pulse", m_done, 1'b1);
    chk("idle_busy", m_busy, 1'b0);
    chk("idle_valid", m_valid, 1'b0);
    @(posedge clk); #1;
    chk("done_cleared", m_done, 1'b0);
  endtask

  localparam logic [127:0] D_EMPTY = {32'hd98c1dd4, 32'h04b2008f, 32'h980980e9, 32'h7e42f8ec};
  localparam logic [127:0] D_IV    = {32'h01234567, 32'h89abcdef, 32'hfedcba98, 32'h76543210};
  localparam logic [127:0] D_ABC   = {32'h98500190, 32'hb04fd23c, 32'h7d3f96d6, 32'h727fe128};

  initial begin
    string s_le;
    string s_be;
    string s_iv;
    string s_abc;
    s_le  = "d41d8cd98f00b204e9800998ecf8427e";
    s_be  = "d98c1dd404b2008f980980e97e42f8ec";
    s_iv  = "67452301efcdab8998badcfe10325476";
    s_abc = "900150983cd24fb0d6963f7d28e17f72";

    reset = 1'b1; dv = 1'b0; sel = 1'b0; rdy = 1'b0;
    dg_a = '0; dg_b = '0; dg_c = '0; dg_d = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", a_valid, 1'b0);
    chk("rst_data", a_data, 8'h00);
    chk("rst_last", a_last, 1'b0);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_done", a_done, 1'b0);
    chk("rst_overrun", a_ovr, 1'b0);
    chk("rst_b_valid", b_valid, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Empty-string digest, ready held high: one char per cycle
    start(D_EMPTY);
    stream(s_le, 0, 0, 1'b0);

    // Same digest under toggling and random back-pressure
    start(D_EMPTY);
    stream(s_le, 1, 0, 1'b0);
    start(D_EMPTY);
    stream(s_le, 2, 0, 1'b0);
    chk("no_overrun_yet", m_ovr, 1'b0);

    // Digests during streaming and on the final handshake are dropped
    start(D_IV);
    stream(s_iv, 0, 0, 1'b1);
    chk("overrun_set", m_ovr, 1'b1);
    // Digest in the cycle after done is accepted
    start(D_ABC);
    stream(s_abc, 0, 0, 1'b0);
    chk("overrun_sticky", m_ovr, 1'b1);

    // Reset mid-stream at char 17, with a coincident digest_valid
    start(D_EMPTY);
    rdy = 1'b1;
    repeat (17) begin
      @(posedge clk); #1;
    end
    chk("pre_reset_char17", m_data, exp_char(s_le, 17));
    reset = 1'b1;
    dv = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    dv = 1'b0;
    rdy = 1'b0;
    chk("midrst_valid", m_valid, 1'b0);
    chk("midrst_busy", m_busy, 1'b0);
    chk("midrst_overrun", m_ovr, 1'b0);
    chk("midrst_data", m_data, 8'h00);
    chk("midrst_last", m_last, 1'b0);
    @(posedge clk); #1;
    chk("rst_wins_no_capture", m_valid, 1'b0);
    start(D_IV);
    stream(s_iv, 2, 0, 1'b0);

    // Raw MSB-first ordering with three idle cycles between characters
    sel = 1'b1;
    @(posedge clk); #1;
    start(D_EMPTY);
    stream(s_be, 0, 3, 1'b0);
    start(D_ABC);
    stream("98500190b04fd23c7d3f96d6727fe128", 1, 3, 1'b0);
    chk("b_overrun_clear", m_ovr, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_md5_hex_out
`default_nettype wire
